axil_mem: RTL and testbench
===========================

AXIL_MEM -- requirements
Module: axil_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning AXI4-Lite address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width in bits; legal values are 32 and 64.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of DATA_W-bit words; it must be a power of two and at least 2.
REQ-004 The block SHALL have port clock, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: reset is synchronous and active-low.
REQ-006 The block SHALL have the AW ports AWVALID in 1, AWREADY out 1, and AWADDR in ADDR_W.
REQ-007 The block SHALL have the W ports WVALID in 1, WREADY out 1, WDATA in DATA_W, and WSTRB in DATA_W/8.
REQ-008 The block SHALL have the B ports BVALID out 1 and BREADY in 1.
REQ-009 The block SHALL have the AR ports ARVALID in 1, ARREADY out 1, and ARADDR in ADDR_W.
REQ-010 The block SHALL have the R ports RVALID out 1, RREADY in 1, and RDATA out DATA_W.

Function
REQ-011 The block SHALL compute the word index as addr[LSB+log2(DEPTH)-1:LSB], with LSB=log2(DATA_W/8). An address is in range when addr < DEPTH*DATA_W/8; unaligned low bits are ignored.
REQ-012 The AW and W channels SHALL be accepted independently, in either order or in the same cycle. Each has a one-entry holding register; AWREADY = !aw_held and WREADY = !w_held.
REQ-013 The memory SHALL be written in the cycle after both holding registers are full and BVALID is low. Only bytes with WSTRB[i]=1 are written, and both holding registers clear in that cycle.
REQ-014 BVALID SHALL rise in the cycle after the memory write and hold until BREADY=1; no second write commits while BVALID=1.
REQ-015 Write FSM states SHALL be IDLE, HAVE_AW, HAVE_W, COMMIT, and RESP. COMMIT is entered when both AW and W are held, and goes to RESP. RESP goes to IDLE on BREADY, or to HAVE_AW/HAVE_W if a new beat was accepted during RESP.
REQ-016 ARREADY SHALL equal !RVALID | RREADY, giving one read outstanding and full throughput with RREADY held high.
REQ-017 Read latency SHALL be 1 cycle: RVALID is high in the cycle after the AR handshake, and RDATA is stable while RVALID=1 and RREADY=0.
REQ-018 A read and a memory write to the same word in the same cycle SHALL return the pre-write data (read-before-write).
REQ-019 An out-of-range write SHALL change no memory and still complete a B response. An out-of-range read SHALL return RDATA=0.

Reset
REQ-020 While reset=0 at a clock edge, the block SHALL drive AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, and RDATA=0.
REQ-021 Reset SHALL clear the holding registers and return the FSM to IDLE. In-flight transactions are discarded and a held but uncommitted write is not performed.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 AWREADY, WREADY, and ARREADY SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-024 With AXIL_MEM_RESP_EN defined, the block SHALL add output ports BRESP[1:0] and RRESP[1:0]. These carry 2'b00 OKAY for in-range accesses and 2'b10 SLVERR for out-of-range accesses, are valid with BVALID/RVALID, and reset to 2'b00.
REQ-025 Without AXIL_MEM_RESP_EN, the block SHALL have no BRESP/RRESP ports, and out-of-range behaviour SHALL follow REQ-019 with no error indication.

Structure
REQ-026 Package axil_mem_pkg SHALL hold the resp_t type (OKAY=2'b00, SLVERR=2'b10), the write FSM state enum, and the derived-width helper constants.
REQ-027 The storage SHALL be the sub-module axil_mem_ram: one byte-enable write port and one synchronous read port, parameterised by DATA_W and DEPTH, with no reset.

Verification
REQ-028 Write then read test: AW 0x10 and W 0xDEADBEEF with WSTRB 0xF in the same cycle, then AR 0x10. Required: BVALID 2 cycles after the handshake, and RDATA 0xDEADBEEF 1 cycle after AR.
REQ-029 Write-strobe and ordering test: write 0x11223344, then W 0xAABBCCDD with WSTRB 0x5 accepted 3 cycles before its AW. Required: read returns 0x11BB33DD.
REQ-030 Backpressure test: hold BREADY=0 for 5 cycles. Required: BVALID stays high, and the next AW/W is accepted but not committed until after the B handshake. Hold RREADY=0. Required: RDATA stable and ARREADY=0.
REQ-031 Back-to-back read test: RREADY=1 with ARVALID=1 for 4 cycles at addresses 0, 4, 8, 12. Required: 4 consecutive RVALID beats in order.
REQ-032 Out-of-range test: DEPTH=1024, write then read at 0x1000. Required: memory unchanged, RDATA 0, and with AXIL_MEM_RESP_EN, BRESP/RRESP = 2'b10.
REQ-033 Reset mid-write test: AW accepted, then reset=0 for 1 cycle, then W sent. Required: no B response and no memory change; all READY outputs are 0 during reset and 1 in the following cycle.

Source files
------------

// File: rtl/axil_mem_pkg.sv
// Shared types and width helpers for the axil_mem AXI4-Lite memory.
package axil_mem_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StHaveAw,
    StHaveW,
    StCommit,
    StResp
  } wr_state_e;

  localparam int unsigned ByteW = 8;

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / ByteW;
  endfunction

  function automatic int unsigned lsb_w(input int unsigned data_w);
    return $clog2(data_w / ByteW);
  endfunction

endpackage

// File: rtl/axil_mem_ram.sv
// Word-addressed storage: one byte-enable write port, one synchronous read port, no reset.
module axil_mem_ram
  import axil_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int unsigned StrbW = strb_w(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read of the old word gives read-before-write on a same-word collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < StrbW; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][ByteW*i +: ByteW] <= wdata_i[ByteW*i +: ByteW];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem.sv
// AXI4-Lite slave memory with decoupled AW/W holding registers and 1-cycle reads.
// Define AXIL_MEM_RESP_EN to add BRESP/RRESP ports (SLVERR on out-of-range access).
module axil_mem
  import axil_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA
`ifdef AXIL_MEM_RESP_EN
  ,
  output logic [1:0]          BRESP,
  output logic [1:0]          RRESP
`endif
);

  localparam int unsigned Lsb   = lsb_w(DATA_W);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned StrbW = strb_w(DATA_W);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> (Lsb + IdxW)) == '0;
  endfunction

  function automatic wr_state_e hold_state(input logic aw, input logic w);
    if (aw && w) return StCommit;
    if (aw)      return StHaveAw;
    if (w)       return StHaveW;
    return StIdle;
  endfunction

  wr_state_e         state_q, state_d;
  logic              active_q;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IdxW-1:0]   aw_idx_q, aw_idx_d;
  logic              aw_ok_q, aw_ok_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]  w_strb_q, w_strb_d;
  logic              rvalid_q, rvalid_d, rd_ok_q, rd_ok_d;
  logic              aw_hs, w_hs, ar_hs, commit, mem_we;
  logic [DATA_W-1:0] ram_rdata;

  // active_q keeps all READYs low for the cycle following any reset edge.
  assign AWREADY = active_q & ~aw_held_q;
  assign WREADY  = active_q & ~w_held_q;
  assign ARREADY = active_q & (~rvalid_q | RREADY);
  assign BVALID  = (state_q == StResp);
  assign RVALID  = rvalid_q;
  assign RDATA   = rd_ok_q ? ram_rdata : '0;

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign mem_we = commit & aw_ok_q & reset;

  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d  = w_held_q | w_hs;
    aw_idx_d  = aw_hs ? AWADDR[Lsb +: IdxW] : aw_idx_q;
    aw_ok_d   = aw_hs ? in_range(AWADDR) : aw_ok_q;
    w_data_d  = w_hs ? WDATA : w_data_q;
    w_strb_d  = w_hs ? WSTRB : w_strb_q;
    rvalid_d  = ar_hs ? 1'b1 : (rvalid_q & ~RREADY);
    rd_ok_d   = ar_hs ? in_range(ARADDR) : rd_ok_q;
    unique case (state_q)
      StIdle, StHaveAw, StHaveW: state_d = hold_state(aw_held_d, w_held_d);
      StCommit: begin
        commit    = 1'b1;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        state_d   = StResp;
      end
      StResp: if (BREADY) state_d = hold_state(aw_held_d, w_held_d);
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      active_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      rvalid_q  <= rvalid_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  // Payload registers are qualified by the held flags, so they need no reset.
  always_ff @(posedge clock) begin
    aw_idx_q <= aw_idx_d;
    aw_ok_q  <= aw_ok_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

`ifdef AXIL_MEM_RESP_EN
  logic b_err_q, b_err_d;

  always_comb begin
    b_err_d = b_err_q;
    if (commit) b_err_d = ~aw_ok_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) b_err_q <= 1'b0;
    else        b_err_q <= b_err_d;
  end

  assign BRESP = (BVALID && b_err_q) ? RespSlverr : RespOkay;
  assign RRESP = (rvalid_q && !rd_ok_q) ? RespSlverr : RespOkay;
`endif

  axil_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (aw_idx_q),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .re_i    (ar_hs & in_range(ARADDR)),
    .raddr_i (ARADDR[Lsb +: IdxW]),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_axil_mem.sv
// Directed bench for axil_mem with a transaction-level memory model and per-cycle monitor.
module tb_axil_mem;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1, ARVALID = 1'b0, RREADY = 1'b1;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [DW-1:0] RDATA;
`ifdef AXIL_MEM_RESP_EN
  logic [1:0]    BRESP, RRESP;
`endif

  axil_mem #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA)
`ifdef AXIL_MEM_RESP_EN
    ,
    .BRESP   (BRESP),
    .RRESP   (RRESP)
`endif
  );

  initial forever #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no event required one", name);
  endtask

  // Byte-granular memory model; writes land once BVALID shows they committed.
  logic [31:0] mdl [DEP];
  logic [31:0] awq[$];
  logic [31:0] wdq[$];
  logic [3:0]  wsq[$];
  logic [31:0] rq[$];

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (a >= DEP * 4) return 32'h0;
    return mdl[a[11:2]];
  endfunction

  function automatic void mdl_apply(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] s);
    if (a < DEP * 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[11:2]][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  bit          b_seen = 0, live = 0, prev_stall = 0;
  logic [31:0] prev_rdata = '0;

  always @(negedge clock) begin
    if (!reset) begin
      awq.delete(); wdq.delete(); wsq.delete(); rq.delete();
      b_seen = 0; live = 0; prev_stall = 0;
    end else begin
      if (live) begin
        chk("arready_rule", ARREADY, !RVALID || RREADY);
        if (prev_stall) begin
          chk("rvalid_hold", RVALID, 1'b1);
          chk("rdata_stable", RDATA, prev_rdata);
        end
        if (BVALID && !b_seen) begin
          if (awq.size() == 0 || wdq.size() == 0) note_fail("b_without_write");
          else begin
`ifdef AXIL_MEM_RESP_EN
            chk("bresp_model", BRESP, (awq[0] < DEP * 4) ? 2'b00 : 2'b10);
`endif
            mdl_apply(awq.pop_front(), wdq.pop_front(), wsq.pop_front());
          end
          b_seen = 1;
        end
        if (BVALID && BREADY) b_seen = 0;
        if (RVALID) begin
          if (rq.size() == 0) note_fail("r_without_ar");
          else begin
            chk("rdata_model", RDATA, rq[0]);
            if (RREADY) void'(rq.pop_front());
          end
        end
        if (ARVALID && ARREADY) rq.push_back(mdl_read(ARADDR));
        if (AWVALID && AWREADY) awq.push_back(AWADDR);
        if (WVALID && WREADY) begin
          wdq.push_back(WDATA);
          wsq.push_back(WSTRB);
        end
        prev_stall = RVALID && !RREADY;
        prev_rdata = RDATA;
      end
      live = 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done = 0;
    bit w_done = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    for (int t = 0; t < 20 && !(aw_done && w_done); t++) begin
      @(negedge clock);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      tick();
      if (aw_done) AWVALID = 0;
      if (w_done) WVALID = 0;
    end
    if (!(aw_done && w_done)) note_fail("write_accept_timeout");
    AWVALID = 0; WVALID = 0;
  endtask

  // Returns at the negedge where BVALID is seen high.
  task automatic wait_b(input string name);
    bit got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      if (BVALID) got = 1;
      else tick();
    end
    if (!got) note_fail(name);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp, input logic [1:0] er,
                          input string name);
    bit hs = 0;
    ARADDR = a; ARVALID = 1;
    for (int t = 0; t < 20 && !hs; t++) begin
      @(negedge clock);
      if (ARREADY) hs = 1;
      tick();
    end
    ARVALID = 0;
    if (!hs) note_fail({name, "_ar_timeout"});
    else begin
      @(negedge clock);
      chk({name, "_rvalid"}, RVALID, 1'b1);
      chk({name, "_rdata"}, RDATA, exp);
`ifdef AXIL_MEM_RESP_EN
      chk({name, "_rresp"}, RRESP, er);
`else
      if (er > 2'b10) $display("note: unexpected response code %0d", er);
`endif
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clock);
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rdata", RDATA, 32'h0);
`ifdef AXIL_MEM_RESP_EN
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_rresp", RRESP, 2'b00);
`endif
    tick();
    reset = 1;
    tick();
    @(negedge clock);
    chk("post_rst_awready", AWREADY, 1'b1);
    chk("post_rst_wready", WREADY, 1'b1);
    chk("post_rst_arready", ARREADY, 1'b1);
    tick();

    // Write then read, AW and W together
    axi_write(32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clock);
    chk("t028_bvalid_1cyc", BVALID, 1'b0);
    tick();
    @(negedge clock);
    chk("t028_bvalid_2cyc", BVALID, 1'b1);
    tick();
    axi_read(32'h10, 32'hDEADBEEF, 2'b00, "t028");

    // Strobes with W arriving 3 cycles before AW
    axi_write(32'h20, 32'h11223344, 4'hF);
    wait_b("t029_b1_timeout");
    tick();
    WDATA = 32'hAABBCCDD; WSTRB = 4'h5; WVALID = 1;
    @(negedge clock);
    chk("t029_wready", WREADY, 1'b1);
    tick();
    WVALID = 0;
    @(negedge clock);
    chk("t029_w_held", WREADY, 1'b0);
    chk("t029_aw_free", AWREADY, 1'b1);
    tick();
    tick();
    AWADDR = 32'h20; AWVALID = 1;
    @(negedge clock);
    chk("t029_awready", AWREADY, 1'b1);
    tick();
    AWVALID = 0;
    wait_b("t029_b2_timeout");
    tick();
    axi_read(32'h20, 32'h11BB33DD, 2'b00, "t029");

    // B and R backpressure
    BREADY = 0;
    axi_write(32'h30, 32'h01020304, 4'hF);
    wait_b("t030_b1_timeout");
    tick();
    axi_write(32'h30, 32'h55667788, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t030_bvalid_hold", BVALID, 1'b1);
      chk("t030_aw_blocked", AWREADY, 1'b0);
      tick();
    end
    axi_read(32'h30, 32'h01020304, 2'b00, "t030_pre");
    BREADY = 1;
    @(negedge clock);
    chk("t030_bvalid_before_hs", BVALID, 1'b1);
    tick();
    @(negedge clock);
    chk("t030_commit_gap", BVALID, 1'b0);
    tick();
    wait_b("t030_b2_timeout");
    tick();
    RREADY = 0;
    ARADDR = 32'h30; ARVALID = 1;
    @(negedge clock);
    chk("t030_arready", ARREADY, 1'b1);
    tick();
    ARVALID = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t030_rvalid_stall", RVALID, 1'b1);
      chk("t030_arready_stall", ARREADY, 1'b0);
      chk("t030_rdata_stall", RDATA, 32'h55667788);
      tick();
    end
    RREADY = 1;
    @(negedge clock);
    chk("t030_rvalid_release", RVALID, 1'b1);
    tick();

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      axi_write(32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      wait_b("t031_b_timeout");
      tick();
    end
    ARVALID = 1;
    for (int i = 0; i < 4; i++) begin
      ARADDR = 32'(4 * i);
      @(negedge clock);
      chk("t031_arready", ARREADY, 1'b1);
      if (i > 0) begin
        chk("t031_rvalid", RVALID, 1'b1);
        chk("t031_rdata", RDATA, 32'hA000_0000 + 32'(i - 1));
      end
      tick();
    end
    ARVALID = 0;
    @(negedge clock);
    chk("t031_rvalid_last", RVALID, 1'b1);
    chk("t031_rdata_last", RDATA, 32'hA000_0003);
    tick();

    // Out-of-range write and read
    axi_write(32'h1000, 32'hCAFEF00D, 4'hF);
    wait_b("t032_b_timeout");
`ifdef AXIL_MEM_RESP_EN
    chk("t032_bresp", BRESP, 2'b10);
`endif
    tick();
    axi_read(32'h1000, 32'h0, 2'b10, "t032_oor");
    axi_read(32'h0, 32'hA000_0000, 2'b00, "t032_word0");

    // Reset between AW and W
    axi_write(32'h40, 32'h12345678, 4'hF);
    wait_b("t033_b_timeout");
    tick();
    AWADDR = 32'h40; AWVALID = 1;
    @(negedge clock);
    chk("t033_awready", AWREADY, 1'b1);
    tick();
    AWVALID = 0;
    reset = 0;
    tick();
    @(negedge clock);
    chk("t033_rst_awready", AWREADY, 1'b0);
    chk("t033_rst_wready", WREADY, 1'b0);
    chk("t033_rst_arready", ARREADY, 1'b0);
    chk("t033_rst_bvalid", BVALID, 1'b0);
    chk("t033_rst_rvalid", RVALID, 1'b0);
    #1 reset = 1;
    @(negedge clock);
    chk("t033_post_awready", AWREADY, 1'b1);
    chk("t033_post_wready", WREADY, 1'b1);
    chk("t033_post_arready", ARREADY, 1'b1);
    tick();
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
    @(negedge clock);
    chk("t033_wready", WREADY, 1'b1);
    tick();
    WVALID = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("t033_no_b", BVALID, 1'b0);
      tick();
    end
    axi_read(32'h40, 32'h12345678, 2'b00, "t033");

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
